// File: rtl/mem_arbiter_sj.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// Data wins by default; after MAX_DATA_STREAK consecutive data grants with a
// fetch waiting, fetch is forced through. One transaction is outstanding at a
// time, and each response is steered back to the port that issued it.
module mem_arbiter_sj #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    // data port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    // memory side
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // status
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  if_stall_cnt
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic          owner_d;   // 1: in-flight transaction belongs to the data port
    logic [SW-1:0] streak;    // data grants in a row while a fetch was waiting
    logic          pick_d;
    logic          take_rsp;

    // Data wins unless a waiting fetch has been passed over too many times.
    assign pick_d   = d_req && !(if_req && (streak == STREAK_MAX));
    assign d_gnt    = (state == IDLE) && pick_d;
    assign if_gnt   = (state == IDLE) && if_req && !pick_d;
    assign busy     = (state != IDLE);
    // A response is accepted in RESP, or in REQ when grant and response coincide.
    assign take_rsp = mem_rvalid && ((state == RESP) || ((state == REQ) && mem_gnt));

    // Request/grant/response sequencer with registered memory and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= take_rsp && !owner_d;
            d_rvalid  <= take_rsp && owner_d;
            if (take_rsp) begin
                if (owner_d) d_rdata  <= mem_rdata;
                else         if_rdata <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        owner_d   <= 1'b1;
                        state     <= REQ;
                        if (!if_req)                   streak <= '0;
                        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
                    end else if (if_gnt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        owner_d   <= 1'b0;
                        streak    <= '0;
                        state     <= REQ;
                    end else begin
                        mem_req   <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_rvalid ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of cycles a fetch request sits without a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            if_stall_cnt <= '0;
        else if (if_req && !if_gnt && (if_stall_cnt != {CNT_WIDTH{1'b1}}))
            if_stall_cnt <= if_stall_cnt + 1'b1;
    end

endmodule

// File: doc/mem_arbiter_sj.md
Name: mem_arbiter_sj

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sits between the RV32 core's instr/data interfaces and the memory.
- Arbitrates with fixed data-over-fetch priority plus a fairness limit.
- Sequences a one-outstanding-transaction request/grant/response handshake and routes each response back to its owner.

Parameters:
DATA_WIDTH, 32, width of all data buses
ADDR_WIDTH, 32, width of all address buses
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (>=1)
CNT_WIDTH, 16, width of the fetch-stall performance counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch request accepted (combinational, IDLE only)
if_rvalid  out  1  one-cycle fetch data valid (registered)
if_rdata  out  DATA_WIDTH  fetch data (registered)
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  data request accepted (combinational, IDLE only)
d_rvalid  out  1  one-cycle load data / store ack (registered)
d_rdata  out  DATA_WIDTH  load data (registered)
mem_req  out  1  memory request (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_WIDTH  memory address (registered)
mem_wdata  out  DATA_WIDTH  memory write data (registered)
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response valid (read data or write ack)
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  transaction in flight (state != IDLE)
if_stall_cnt  out  CNT_WIDTH  count of cycles with if_req=1 and if_gnt=0

Behaviour:

Reset (reset_n=0, asynchronous):
- State goes to IDLE.
- All outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, if_rvalid, d_rvalid, if_rdata, d_rdata, if_stall_cnt.
- Streak counter clears and the owner register clears.
- Reset mid-transaction abandons it. A later stray mem_rvalid is ignored.

FSM states: IDLE, REQ, RESP.

IDLE:
- Selection rule: d_req wins unless if_req=1 and streak==MAX_DATA_STREAK, in which case if_req wins. With only one request pending, that request wins.
- The winner's gnt is asserted combinationally this cycle.
- At the clock edge: capture the winner's addr/we/wdata into the mem_* registers (fetch: we=0, wdata=0), set mem_req=1, record owner, go to REQ.
- Streak update: data grant while if_req=1 gives streak+1 (saturating at MAX_DATA_STREAK). Data grant while if_req=0 gives 0. Fetch grant gives 0.
- No request: stay IDLE, mem_req=0.

REQ:
- mem_req holds and the mem_* registers stay stable until mem_gnt=1.
- On mem_gnt: mem_req drops next cycle and state goes to RESP.
- If mem_gnt and mem_rvalid are both 1 in the same cycle, the response is taken immediately as in RESP, and state goes straight to IDLE.

RESP:
- Wait for mem_rvalid.
- On mem_rvalid: load the owner's rdata register with mem_rdata (stores also load d_rdata), pulse the owner's rvalid for exactly 1 cycle starting next cycle, go to IDLE.

Latency and throughput:
- Minimum latency: request accepted at cycle 0; mem_req at cycle 1; with mem_gnt at 1 and mem_rvalid at 2, rvalid is at cycle 3.
- A new grant may occur in the same cycle the previous rvalid is high. Best-case throughput is one transaction per 3 cycles.

Other rules:
- mem_rvalid in IDLE or in REQ (without mem_gnt) is ignored.
- if_gnt and d_gnt are never both 1, and are never 1 outside IDLE.
- if_rdata and d_rdata hold their value until the next response for that port.
- if_stall_cnt increments each cycle with if_req=1 and if_gnt=0, in any state. It saturates at all-ones.
- Requester dropping req before gnt is legal; the request is simply withdrawn.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x100, memory grants at once and returns 0xDEADBEEF 1 cycle later -> if_gnt at cycle 0, mem_req=1 with mem_addr=0x100 and mem_we=0 at cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 3, d_rvalid stays 0.
2. Simultaneous requests: if_req=d_req=1 in IDLE, d_we=1, d_addr=0x200, d_wdata=0x55 -> d_gnt first, mem_we=1 with mem_wdata=0x55, d_rvalid pulse on ack; fetch granted next, if_stall_cnt=3 at that grant.
3. Fairness: d_req held continuously for 10 transactions with if_req held -> exactly 4 data grants, then 1 fetch grant, then data resumes.
4. Memory backpressure: mem_gnt held 0 for 5 cycles -> mem_req/mem_addr stable all 5 cycles, busy=1, no gnt to either port.
5. Same-cycle mem_gnt and mem_rvalid -> state returns to IDLE directly, rvalid pulses next cycle, a new grant is possible that cycle.
6. Reset mid-transaction: reset_n low while in RESP, then a stray mem_rvalid arrives after release -> all outputs 0, no rvalid pulse, the next request completes normally.
